// File: rtl/gate_deadtime_guard.sv
// Gate-drive conditioner for one inverter leg. It turns the raw Sp/Sn pair into high/low gate commands,
// inserts a dead time on every commutation, and forces both gates off on an external fault or when disabled.
module gate_deadtime_guard #(
    parameter int DT_W = 10
) (
    input  logic            sysclk,
    input  logic            global_rst,
    input  logic            Sp,
    input  logic            Sn,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic            enable,
    input  logic            fault_n,
    input  logic            fault_clr,
    output logic            gate_p,
    output logic            gate_n,
    output logic            fault_latched,
    output logic [7:0]      illegal_cnt
);

    typedef enum logic [1:0] {IDLE, HI, LO, DEAD} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_P, REQ_N} req_t;

    state_t          state;
    req_t            req;
    logic [DT_W-1:0] cnt;
    logic            fault_meta;
    logic            fault_s;
    logic            force_off;

    // 00 and 11 both decode to NONE, so an overlap request always turns both gates off.
    always_comb begin
        req = REQ_NONE;
        if (Sp && !Sn)
            req = REQ_P;
        else if (!Sp && Sn)
            req = REQ_N;
    end

    // NOTE: the synchronizer flops reset to 1 so that a reset does not show up as a phantom fault.
    always_ff @(posedge sysclk or negedge global_rst) begin
        if (!global_rst) begin
            fault_meta <= 1'b1;
            fault_s    <= 1'b1;
        end else begin
            fault_meta <= fault_n;
            fault_s    <= fault_meta;
        end
    end

    assign force_off = !fault_s || fault_latched || !enable;

    // Gate outputs are registered alongside the state, so HI and LO can never both drive.
    always_ff @(posedge sysclk or negedge global_rst) begin
        if (!global_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            gate_p <= 1'b0;
            gate_n <= 1'b0;
        end else if (force_off) begin
            state  <= IDLE;
            cnt    <= '0;
            gate_p <= 1'b0;
            gate_n <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req == REQ_P) begin
                        state  <= HI;
                        gate_p <= 1'b1;
                    end else if (req == REQ_N) begin
                        state  <= LO;
                        gate_n <= 1'b1;
                    end
                end
                HI: begin
                    if (req != REQ_P) begin
                        state  <= DEAD;
                        cnt    <= dt_cycles;
                        gate_p <= 1'b0;
                    end
                end
                LO: begin
                    if (req != REQ_N) begin
                        state  <= DEAD;
                        cnt    <= dt_cycles;
                        gate_n <= 1'b0;
                    end
                end
                DEAD: begin
                    // A zero dead time still costs one cycle with both gates low.
                    if (cnt <= DT_W'(1)) begin
                        case (req)
                            REQ_P: begin
                                state  <= HI;
                                gate_p <= 1'b1;
                            end
                            REQ_N: begin
                                state  <= LO;
                                gate_n <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gate_p <= 1'b0;
                    gate_n <= 1'b0;
                end
            endcase
        end
    end

    // If the fault is still present, setting the latch wins over a clear request.
    always_ff @(posedge sysclk or negedge global_rst) begin
        if (!global_rst)
            fault_latched <= 1'b0;
        else if (!fault_s)
            fault_latched <= 1'b1;
        else if (fault_clr)
            fault_latched <= 1'b0;
    end

    always_ff @(posedge sysclk or negedge global_rst) begin
        if (!global_rst)
            illegal_cnt <= 8'd0;
        else if (fault_clr)
            illegal_cnt <= 8'd0;
        else if (Sp && Sn && illegal_cnt != 8'hFF)
            illegal_cnt <= illegal_cnt + 8'd1;
    end

endmodule
